fxp_square_seq: RTL and testbench

- Sequential fixed-point squarer; the inverse operation of the library's fixed-point square root.
- Accepts a signed WII.WIF value and returns its square as a signed WOI.WOF value, with optional rounding and saturation plus an overflow flag.
- Uses an iterative shift-add multiplier with a valid/ready handshake at both ends.
- Intended as the area-cheap companion to the combinational and pipelined fixed-point operators, and for round-trip self-checks against fxp_sqrt.

---
 rtl/fxp_square_seq_pkg.sv | 64 ++++++
 rtl/fxp_shiftadd_mul_core.sv | 62 ++++++
 rtl/fxp_square_seq.sv | 102 ++++++++++
 tb/tb_fxp_square_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fxp_square_seq_pkg.sv
// ---------------------------------------------------------------------------
// fxp_square_seq_pkg
// Shared definitions for the sequential fixed-point squarer:
//   - state_t        : FSM state encoding (IDLE / MUL / NORM / DONE)
//   - rs_t           : result of the round-and-saturate helper
//   - fxp_round_sat  : rescale an unsigned value by a binary shift, optionally
//                      rounding half-up, and saturate it to a signed output
//                      width (the value is known to be non-negative).
// ---------------------------------------------------------------------------
package fxp_square_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Widest unsigned value the helper accepts; callers zero-extend into it.
  localparam int RS_W = 64;

  typedef struct packed {
    logic [RS_W-1:0] value;
    logic            ovf;
  } rs_t;

  // shamt > 0 : shift right by shamt (round half-up on the discarded MSB when
  //             round_en is set).
  // shamt <= 0: shift left by -shamt, zero fill.
  // ow        : signed output width; the largest legal result is 2^(ow-1)-1.
  // The working value carries one guard bit above RS_W so a rounding carry
  // can never wrap.
  function automatic rs_t fxp_round_sat(input logic [RS_W-1:0] val,
                                        input int              shamt,
                                        input bit              round_en,
                                        input int              ow);
    rs_t           r;
    logic [RS_W:0] v;
    logic [RS_W:0] max_pos;
    logic          lost;
    r       = '0;
    lost    = 1'b0;
    max_pos = ((RS_W+1)'(1) << (ow - 1)) - (RS_W+1)'(1);
    if (shamt > 0) begin
      v = {1'b0, val} >> shamt;
      if (round_en) begin
        v = v + {{RS_W{1'b0}}, val[shamt-1]};
      end
    end else begin
      v    = {1'b0, val} << (-shamt);
      // Any bit pushed past the guard bit means the value is out of range.
      lost = (({1'b0, val} >> (RS_W + 1 + shamt)) != '0);
    end
    if (lost || (v > max_pos)) begin
      r.value = max_pos[RS_W-1:0];
      r.ovf   = 1'b1;
    end else begin
      r.value = v[RS_W-1:0];
      r.ovf   = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fxp_shiftadd_mul_core.sv
// ---------------------------------------------------------------------------
// fxp_shiftadd_mul_core
// Iterative shift-add squarer core: computes mag*mag over W cycles, one
// multiplier bit per cycle.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    load mag, clear product and bit counter
//   mag      W-bit unsigned operand
//   done     one-cycle pulse: product is complete
//   product  2W-bit unsigned square (held until the next start)
// ---------------------------------------------------------------------------
module fxp_shiftadd_mul_core #(
  parameter int W = 18
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   mag,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int             CW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0]  LAST = CW'(W - 1);

  logic [W-1:0]  mag_q;
  logic [CW-1:0] cnt;
  logic          busy;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q   <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mag_q   <= mag;
        product <= '0;
        cnt     <= '0;
        busy    <= 1'b1;
      end else if (busy) begin
        // (2^W-1)^2 < 2^(2W), so the 2W-bit sum never wraps.
        if (mag_q[cnt]) begin
          product <= product + ({{W{1'b0}}, mag_q} << cnt);
        end
        if (cnt == LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fxp_square_seq.sv
// ---------------------------------------------------------------------------
// fxp_square_seq
// Sequential fixed-point squarer: signed WII.WIF in, signed WOI.WOF out
// (always >= 0), with optional half-up rounding, saturation and an overflow
// flag. valid/ready handshake on both sides, one operation in flight.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   i_valid   operand valid
//   i_ready   block can accept an operand (IDLE only)
//   in        WII+WIF signed operand
//   o_valid   result valid (DONE)
//   o_ready   downstream accepts the result
//   out       WOI+WOF signed result, held until the next result or reset
//   overflow  result was saturated; qualified by o_valid
// ---------------------------------------------------------------------------
module fxp_square_seq
  import fxp_square_seq_pkg::*;
#(
  parameter int WII   = 6,
  parameter int WIF   = 12,
  parameter int WOI   = 10,
  parameter int WOF   = 10,
  parameter int ROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [WII+WIF-1:0]   in,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [WOI+WOF-1:0]   out,
  output logic                 overflow
);

  localparam int W     = WII + WIF;
  localparam int WO    = WOI + WOF;
  // Product carries 2*WIF fraction bits; positive means shift right.
  localparam int SHAMT = 2*WIF - WOF;

  state_t          state, next_state;
  logic            accept;
  logic [W-1:0]    mag;
  logic            core_done;
  logic [2*W-1:0]  product;
  logic [WO-1:0]   norm_val;
  logic            norm_ovf;

  assign accept  = i_valid && i_ready;
  assign o_valid = (state == ST_DONE);

  // |in| as W-bit unsigned; the most negative input maps to 2^(W-1).
  assign mag = in[W-1] ? (~in + 1'b1) : in;

  fxp_shiftadd_mul_core #(.W(W)) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .mag     (mag),
    .done    (core_done),
    .product (product)
  );

  always_comb begin
    rs_t rs;
    rs       = fxp_round_sat(RS_W'(product), SHAMT, (ROUND != 0), WO);
    norm_val = rs.value[WO-1:0];
    norm_ovf = rs.ovf;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept)    next_state = ST_MUL;
      ST_MUL:  if (core_done) next_state = ST_NORM;
      ST_NORM:                next_state = ST_DONE;
      ST_DONE: if (o_ready)   next_state = ST_IDLE;
      default:                next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      i_ready  <= 1'b0;
      out      <= '0;
      overflow <= 1'b0;
    end else begin
      state   <= next_state;
      // Registered so it stays low through the reset cycle itself.
      i_ready <= (next_state == ST_IDLE);
      if (state == ST_NORM) begin
        out      <= norm_val;
        overflow <= norm_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fxp_square_seq.sv
// ---------------------------------------------------------------------------
// tb_fxp_square_seq
// Scoreboarded bench for fxp_square_seq. Two instances share stimulus: the
// default (ROUND=1) and a truncating one (ROUND=0). Expected results are
// queued when an operand is issued; a monitor pops on each output handshake.
// ---------------------------------------------------------------------------
module tb_fxp_square_seq;

  localparam int LAT = 20;

  typedef struct {
    logic [19:0] exp;
    bit          ovf;
    bit          rt;
    int          y;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [17:0] din;
  logic        i_ready,  o_valid,  overflow;
  logic [19:0] out;
  logic        i_ready0, o_valid0, overflow0;
  logic [19:0] out0;

  int tests;
  int fails;
  exp_t q1[$];
  exp_t q0[$];

  fxp_square_seq #(.ROUND(1)) u_dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .in(din),
    .o_valid(o_valid), .o_ready(o_ready), .out(out), .overflow(overflow)
  );

  fxp_square_seq #(.ROUND(0)) u_dut_trunc (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready0), .in(din),
    .o_valid(o_valid0), .o_ready(o_ready), .out(out0), .overflow(overflow0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input longint act, input longint expv);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: square the real value, scale to 10 fraction bits, round or
  // truncate, clamp to the largest positive 10.10 code.
  function automatic exp_t model(input logic [17:0] x, input bit rnd);
    exp_t   e;
    real    xv, v;
    longint q;
    xv = $itor($signed(x)) / 4096.0;
    v  = xv * xv * 1024.0;
    q  = rnd ? longint'($rtoi(v + 0.5)) : longint'($rtoi(v));
    e.rt = 1'b0;
    e.y  = 0;
    if (q > 524287) begin
      e.exp = 20'h7FFFF;
      e.ovf = 1'b1;
    end else begin
      e.exp = 20'(q);
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  // Issue one operand, queue expectations, verify latency and (optionally)
  // that o_valid is a single-cycle pulse with o_ready high.
  task automatic send(input logic [17:0] x, input exp_t e1, input exp_t e0, input bit pulse_chk);
    int waited;
    int lat;
    waited = 0;
    @(negedge clk);
    while (!i_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check(i_ready == 1'b1, "i_ready_wait", i_ready, 1);
    q1.push_back(e1);
    q0.push_back(e0);
    din     = x;
    i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check(lat == LAT, "latency", lat, LAT);
    check(i_ready == 1'b0, "i_ready_busy", i_ready, 0);
    if (pulse_chk) begin
      @(posedge clk);
      #1;
      check(o_valid == 1'b0, "single_pulse", o_valid, 0);
    end
  endtask

  task automatic send_const(input logic [17:0] x, input logic [19:0] r1, input bit v1,
                            input logic [19:0] r0, input bit v0);
    exp_t e1, e0;
    e1 = '{exp: r1, ovf: v1, rt: 1'b0, y: 0};
    e0 = '{exp: r0, ovf: v0, rt: 1'b0, y: 0};
    send(x, e1, e0, 1'b1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int   d;
    if (!rst && o_valid === 1'b1 && o_ready) begin
      check(q1.size() != 0, "unexpected_o_valid", out, 0);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check(out == e.exp, "out", out, e.exp);
        check(overflow == e.ovf, "overflow", overflow, e.ovf);
        if (e.rt) begin
          d = int'(out) - e.y;
          check(d <= 1 && d >= -1, "round_trip", out, e.y);
        end
      end
    end
    if (!rst && o_valid0 === 1'b1 && o_ready) begin
      check(q0.size() != 0, "unexpected_o_valid_trunc", out0, 0);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check(out0 == e.exp, "out_trunc", out0, e.exp);
        check(overflow0 == e.ovf, "overflow_trunc", overflow0, e.ovf);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [19:0] held;
    exp_t        e1, e0;
    int          y;
    logic [17:0] s;
    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    i_valid = 1'b0;
    o_ready = 1'b1;
    din     = '0;

    // Reset
    repeat (4) @(posedge clk);
    #1;
    check(i_ready == 1'b0, "rst_i_ready_held", i_ready, 0);
    check(o_valid == 1'b0, "rst_o_valid_held", o_valid, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check(i_ready == 1'b1, "rst_i_ready", i_ready, 1);
    check(o_valid == 1'b0, "rst_o_valid", o_valid, 0);
    check(out == 20'h0, "rst_out", out, 0);
    check(overflow == 1'b0, "rst_overflow", overflow, 0);

    // Directed values
    send_const(18'h03000, 20'h02400, 1'b0, 20'h02400, 1'b0);  // 3.0 -> 9.0
    send_const(18'h3E800, 20'h00900, 1'b0, 20'h00900, 1'b0);  // -1.5 -> 2.25
    send_const(18'h00000, 20'h00000, 1'b0, 20'h00000, 1'b0);
    send_const(18'h00080, 20'h00001, 1'b0, 20'h00001, 1'b0);  // 2^-5 -> 2^-10
    send_const(18'h000A0, 20'h00002, 1'b0, 20'h00001, 1'b0);  // round vs truncate
    send_const(18'h1FFFF, 20'h7FFFF, 1'b1, 20'h7FFFF, 1'b1);
    send_const(18'h20000, 20'h7FFFF, 1'b1, 20'h7FFFF, 1'b1);

    // Back-pressure in DONE: outputs hold, new operands ignored
    o_ready = 1'b0;
    e1 = '{exp: 20'h00900, ovf: 1'b0, rt: 1'b0, y: 0};
    send(18'h01800, e1, e1, 1'b0);
    held = out;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check(o_valid == 1'b1, "stall_o_valid", o_valid, 1);
      check(out == held, "stall_out", out, held);
      check(i_ready == 1'b0, "stall_i_ready", i_ready, 0);
      i_valid = i[0];
      din     = 18'($urandom);
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    @(posedge clk);
    #1;
    check(o_valid == 1'b0, "stall_release", o_valid, 0);
    check(i_ready == 1'b1, "stall_back_idle", i_ready, 1);

    // Reset during MUL discards the operation
    @(negedge clk);
    din     = 18'h03000;
    i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check(i_ready == 1'b0, "mulrst_i_ready_low", i_ready, 0);
    check(o_valid == 1'b0, "mulrst_o_valid", o_valid, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check(i_ready == 1'b1, "mulrst_i_ready", i_ready, 1);
    check(out == 20'h0, "mulrst_out", out, 0);
    check(overflow == 1'b0, "mulrst_overflow", overflow, 0);
    repeat (30) @(posedge clk);
    #1;
    check(o_valid == 1'b0, "mulrst_no_result", o_valid, 0);

    // Random operands against the real-arithmetic model
    for (int i = 0; i < 40; i++) begin
      s  = 18'($urandom);
      e1 = model(s, 1'b1);
      e0 = model(s, 1'b0);
      send(s, e1, e0, 1'b1);
    end

    // Round-trip: rounded sqrt of a 10.10 value, squared back
    for (int i = 0; i < 8; i++) begin
      y  = int'($urandom_range(0, 4095));
      s  = 18'($rtoi($sqrt($itor(y) / 1024.0) * 4096.0 + 0.5));
      e1 = model(s, 1'b1);
      e1.rt = 1'b1;
      e1.y  = y;
      e0 = model(s, 1'b0);
      send(s, e1, e0, 1'b1);
    end

    repeat (5) @(posedge clk);
    #1;
    check(q1.size() == 0, "scoreboard_drained", q1.size(), 0);
    check(q0.size() == 0, "scoreboard_drained_trunc", q0.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
